wb_arb_stage: RTL and testbench
===============================

# wb_arb_stage

Parametrised write-back stage for the MIPS16 pipeline that merges NUM_CH independent result channels (e.g. ALU and load unit) onto the single register-file write port. Each channel has a valid/ready handshake into a private FIFO. A round-robin arbiter drains one entry per cycle into registered write-port outputs. It also exports an in-flight destination mask for the hazard/forwarding logic.

## Interface
- DATA_W, 16, register data width
- ADDR_W, 3, register address width
- NUM_CH, 2, number of producer channels (1..8)
- FIFO_DEPTH, 4, entries per channel FIFO (power of 2, ≥2)
- R0_SUPPRESS, 1, when 1, writes to register 0 are discarded at input
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous active-low reset
- in_valid  in  NUM_CH  per-channel request
- in_ready  out  NUM_CH  per-channel accept; `in_ready[i] = rst && !full[i]`
- in_we  in  NUM_CH  per-channel write enable of the offered result
- in_dest  in  NUM_CH*ADDR_W  channel i at bits [i*ADDR_W +: ADDR_W]
- in_data  in  NUM_CH*DATA_W  channel i at bits [i*DATA_W +: DATA_W]
- reg_write_en  out  1  register-file write strobe
- reg_write_dest  out  ADDR_W  register-file write address
- reg_write_data  out  DATA_W  register-file write data
- wb_op_dest  out  ADDR_W  reg_write_dest when reg_write_en, else 0
- pending_mask  out  2**ADDR_W  bit d set while a write to d is queued or on the output

## Operation
- Handshake: transfer on channel i when `in_valid[i] && in_ready[i]` at a rising edge. The transfer is not enqueued (the beat is consumed and dropped) when either of these holds:
  - in_we=0
  - R0_SUPPRESS=1 and in_dest=0
- in_ready depends only on the registered occupancy count. There is no combinational path from a pop.
  - A full FIFO refuses a push in the same cycle it pops.
- Each FIFO preserves order within its channel. There is no ordering guarantee across channels.
- Arbiter: a round-robin pointer rr (width clog2(NUM_CH), reset 0).
  - Each cycle, the winner is the first non-empty FIFO searching rr, rr+1, … modulo NUM_CH.
  - On a pop, rr ← winner+1, wrapping NUM_CH-1 → 0.
  - If no FIFO is non-empty, there is no pop and rr holds.
- Output registers load on every edge:
  - On a pop: en=1, dest/data from the popped entry.
  - Otherwise: en=0, dest=0, data=0.
- pending_mask is the combinational OR over all valid FIFO entries' dest, plus reg_write_dest when reg_write_en.
- FIFO pointers are clog2(FIFO_DEPTH) bits wrapping naturally. Occupancy is clog2(FIFO_DEPTH)+1 bits. A simultaneous push+pop on a non-full FIFO leaves occupancy unchanged.

## Timing
- Reset (rst low, asynchronous) clears all of the following immediately:
  - all outputs 0: in_ready=0, reg_write_en=0, reg_write_dest=0, reg_write_data=0, wb_op_dest=0, pending_mask=0
  - FIFOs emptied, rr=0
- Reset asserted mid-operation discards all queued entries; none are written after release.
- First cycle after release: in_ready all 1.
- Latency: a beat accepted at edge N into an empty system with no competing traffic is popped at edge N+1. reg_write_en is high for the cycle following edge N+1.
- Throughput: one register write per cycle aggregate. Each channel sustains one beat per cycle only while the others are idle.
- Starvation bound: a non-empty FIFO is served within NUM_CH pops.

## Structure
- Package mips_16_wb_pkg holds:
  - default parameter constants (WB_DATA_W=16, WB_ADDR_W=3)
  - the enqueued entry struct {dest, data} (we is implicit: only writes are stored)
  - a round-robin next-grant function
- One sub-module, wb_chan_fifo: a single-channel synchronous FIFO, instantiated NUM_CH times via generate.
  - Ports: push, pop, entry in/out, full, empty, plus a valid-entry dest vector for pending_mask.
- The top holds the arbiter, output registers and mask logic.
- Assertions bind to the top, matching existing stage assertion modules:
  - no reg_write_en with dest 0 when R0_SUPPRESS
  - no push when full

## Test plan
- Reset release, single push on ch0 (we=1, dest=3, data=16'h1234) at edge 1 → reg_write_en=1, dest=3, data=16'h1234 in cycle after edge 2; pending_mask[3]=1 from edge 1 until en drops.
- Both channels push every cycle for 8 cycles (ch0 dest=1, ch1 dest=2) → writes alternate 1,2,1,2…; each in_ready drops to 0 once its FIFO holds 4; no beat lost, in-order per channel.
- Fill ch1 to 4 entries while output is stalled by ch0 traffic, keep in_valid[1]=1 → in_ready[1]=0 in the cycle a pop occurs; accepted count stays exactly 4 that edge.
- Push we=0 (dest=5) and we=1 with dest=0 → both accepted (in_ready=1), no reg_write_en, pending_mask stays 0.
- Queue 3 entries, assert rst low between edges → outputs and pending_mask 0 immediately; after release no write from old entries occurs.
- NUM_CH=3, FIFO_DEPTH=2 build, all channels saturated → grant sequence 0,1,2,0,1,2; rr wraps correctly.

Source files
------------

// File: rtl/mips_16_wb_pkg.sv
// Shared types, default widths and round-robin helper for the MIPS16 write-back stage.
package mips_16_wb_pkg;

   localparam int WB_DATA_W = 16;
   localparam int WB_ADDR_W = 3;

   // Queued result; the write enable is implicit since only writes are stored.
   typedef struct packed {
      logic [WB_ADDR_W-1:0] dest;
      logic [WB_DATA_W-1:0] data;
   } wb_entry_t;

   // Returns {found, index}: first set bit of nonempty searching rr, rr+1, ... mod num_ch.
   function automatic logic [3:0] rr_next_grant(input logic [7:0] nonempty,
                                                input logic [2:0] rr,
                                                input int num_ch);
      logic       found;
      logic [2:0] idx;
      int         cand;
      found = 1'b0;
      idx   = 3'd0;
      cand  = 0;
      for (int k = 0; k < 8; k++) begin
         if ((k < num_ch) && !found) begin
            cand = (int'(rr) + k) % num_ch;
            if (nonempty[cand[2:0]]) begin
               found = 1'b1;
               idx   = cand[2:0];
            end
         end
      end
      return {found, idx};
   endfunction

endpackage

// File: rtl/wb_arb_stage_sva.sv
// Protocol checks for wb_arb_stage, attached to every instance of the top.
module wb_arb_stage_sva (
   input logic clk,
   input logic rst,
   input logic r0_sup,
   input logic reg_write_en,
   input logic dest_zero,
   input logic push_full
);

   a_no_r0_write: assert property (@(posedge clk) disable iff (!rst)
                                   !(r0_sup && reg_write_en && dest_zero));

   a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst) !push_full);

endmodule

bind wb_arb_stage wb_arb_stage_sva u_sva (
   .clk          (clk),
   .rst          (rst),
   .r0_sup       (R0_SUPPRESS != 0),
   .reg_write_en (reg_write_en),
   .dest_zero    (reg_write_dest == '0),
   .push_full    (|(push_s & full_s))
);

// File: rtl/wb_chan_fifo.sv
// Single-channel synchronous FIFO of pending register writes, with a mask of queued destinations.
module wb_chan_fifo
   import mips_16_wb_pkg::*;
#(
   parameter int DATA_W     = WB_DATA_W,
   parameter int ADDR_W     = WB_ADDR_W,
   parameter int FIFO_DEPTH = 4
)(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  logic                   pop,
   input  logic [ADDR_W-1:0]      push_dest,
   input  logic [DATA_W-1:0]      push_data,
   output logic [ADDR_W-1:0]      pop_dest,
   output logic [DATA_W-1:0]      pop_data,
   output logic                   full,
   output logic                   empty,
   output logic [2**ADDR_W-1:0]   dest_mask
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [ADDR_W-1:0] mem_dest_r [FIFO_DEPTH];
   logic [DATA_W-1:0] mem_data_r [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr_r;
   logic [PTR_W-1:0]  rd_ptr_r;
   logic [CNT_W-1:0]  count_r;
   logic [PTR_W-1:0]  slot_s;

   assign full     = (count_r == CNT_W'(FIFO_DEPTH));
   assign empty    = (count_r == '0);
   assign pop_dest = mem_dest_r[rd_ptr_r];
   assign pop_data = mem_data_r[rd_ptr_r];

   // Pointer and occupancy bookkeeping; push+pop together leaves occupancy unchanged.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         count_r  <= '0;
      end else begin
         if (push) begin
            wr_ptr_r <= wr_ptr_r + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_r <= rd_ptr_r + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   count_r <= count_r + CNT_W'(1);
            2'b01:   count_r <= count_r - CNT_W'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   // Entry storage.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_dest_r[i] <= '0;
            mem_data_r[i] <= '0;
         end
      end else if (push) begin
         mem_dest_r[wr_ptr_r] <= push_dest;
         mem_data_r[wr_ptr_r] <= push_data;
      end
   end

   // Destinations of the entries currently between the read pointer and occupancy.
   always_comb begin
      dest_mask = '0;
      slot_s    = '0;
      for (int j = 0; j < FIFO_DEPTH; j++) begin
         slot_s = rd_ptr_r + PTR_W'(j);
         dest_mask[mem_dest_r[slot_s]] = dest_mask[mem_dest_r[slot_s]] | (CNT_W'(j) < count_r);
      end
   end

endmodule

// File: rtl/wb_arb_stage.sv
// Write-back stage: per-channel FIFOs drained round-robin onto a registered register-file write port.
module wb_arb_stage
   import mips_16_wb_pkg::*;
#(
   parameter int DATA_W      = WB_DATA_W,
   parameter int ADDR_W      = WB_ADDR_W,
   parameter int NUM_CH      = 2,
   parameter int FIFO_DEPTH  = 4,
   parameter int R0_SUPPRESS = 1
)(
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_CH-1:0]          in_valid,
   output logic [NUM_CH-1:0]          in_ready,
   input  logic [NUM_CH-1:0]          in_we,
   input  logic [NUM_CH*ADDR_W-1:0]   in_dest,
   input  logic [NUM_CH*DATA_W-1:0]   in_data,
   output logic                       reg_write_en,
   output logic [ADDR_W-1:0]          reg_write_dest,
   output logic [DATA_W-1:0]          reg_write_data,
   output logic [ADDR_W-1:0]          wb_op_dest,
   output logic [2**ADDR_W-1:0]       pending_mask
);

   localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int MASK_W = 2**ADDR_W;

   logic [NUM_CH-1:0]        push_s;
   logic [NUM_CH-1:0]        pop_s;
   logic [NUM_CH-1:0]        full_s;
   logic [NUM_CH-1:0]        empty_s;
   logic [NUM_CH*ADDR_W-1:0] head_dest_s;
   logic [NUM_CH*DATA_W-1:0] head_data_s;
   logic [NUM_CH*MASK_W-1:0] fifo_mask_s;
   logic [7:0]               ne_pad_s;
   logic [2:0]               rr_pad_s;
   logic [3:0]               grant_s;
   logic [CH_W-1:0]          rr_nxt_s;
   logic [ADDR_W-1:0]        win_dest_s;
   logic [DATA_W-1:0]        win_data_s;

   logic [CH_W-1:0]          rr_r;
   logic                     reg_write_en_r;
   logic [ADDR_W-1:0]        reg_write_dest_r;
   logic [DATA_W-1:0]        reg_write_data_r;

   // Ready is a pure function of registered occupancy, never of this cycle's pop.
   assign in_ready = {NUM_CH{rst}} & ~full_s;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      // Beats without a write, or aimed at r0 when suppressed, are consumed but not stored.
      assign push_s[i] = in_valid[i] && in_ready[i] && in_we[i]
                         && !((R0_SUPPRESS != 0) && (in_dest[i*ADDR_W +: ADDR_W] == '0));

      wb_chan_fifo #(
         .DATA_W     (DATA_W),
         .ADDR_W     (ADDR_W),
         .FIFO_DEPTH (FIFO_DEPTH)
      ) u_fifo (
         .clk       (clk),
         .rst       (rst),
         .push      (push_s[i]),
         .pop       (pop_s[i]),
         .push_dest (in_dest[i*ADDR_W +: ADDR_W]),
         .push_data (in_data[i*DATA_W +: DATA_W]),
         .pop_dest  (head_dest_s[i*ADDR_W +: ADDR_W]),
         .pop_data  (head_data_s[i*DATA_W +: DATA_W]),
         .full      (full_s[i]),
         .empty     (empty_s[i]),
         .dest_mask (fifo_mask_s[i*MASK_W +: MASK_W])
      );
   end

   // Round-robin grant, pop select and next pointer.
   always_comb begin
      ne_pad_s   = 8'(~empty_s);
      rr_pad_s   = 3'(rr_r);
      grant_s    = rr_next_grant(ne_pad_s, rr_pad_s, NUM_CH);
      win_dest_s = head_dest_s[grant_s[2:0]*ADDR_W +: ADDR_W];
      win_data_s = head_data_s[grant_s[2:0]*DATA_W +: DATA_W];
      if (grant_s[3]) begin
         pop_s = NUM_CH'(8'd1 << grant_s[2:0]);
      end else begin
         pop_s = '0;
      end
      if (grant_s[2:0] == 3'(NUM_CH - 1)) begin
         rr_nxt_s = '0;
      end else begin
         rr_nxt_s = CH_W'(grant_s[2:0] + 3'd1);
      end
   end

   // Output write port and round-robin pointer; outputs reload every edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rr_r             <= '0;
         reg_write_en_r   <= 1'b0;
         reg_write_dest_r <= '0;
         reg_write_data_r <= '0;
      end else if (grant_s[3]) begin
         rr_r             <= rr_nxt_s;
         reg_write_en_r   <= 1'b1;
         reg_write_dest_r <= win_dest_s;
         reg_write_data_r <= win_data_s;
      end else begin
         rr_r             <= rr_r;
         reg_write_en_r   <= 1'b0;
         reg_write_dest_r <= '0;
         reg_write_data_r <= '0;
      end
   end

   assign reg_write_en   = reg_write_en_r;
   assign reg_write_dest = reg_write_dest_r;
   assign reg_write_data = reg_write_data_r;
   assign wb_op_dest     = reg_write_en_r ? reg_write_dest_r : '0;

   // In-flight destinations for hazard detection: everything queued plus the output register.
   always_comb begin
      pending_mask = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         pending_mask = pending_mask | fifo_mask_s[i*MASK_W +: MASK_W];
      end
      if (reg_write_en_r) begin
         pending_mask[reg_write_dest_r] = 1'b1;
      end else begin
         pending_mask = pending_mask;
      end
   end

endmodule

// File: tb/tb_wb_arb_stage.sv
// Directed, table-driven bench for wb_arb_stage (2-channel default build plus a 3-channel depth-2 build).
module tb_wb_arb_stage;

   logic        clk;
   logic        rst;

   logic [1:0]  in_valid, in_ready, in_we;
   logic [5:0]  in_dest;
   logic [31:0] in_data;
   logic        reg_write_en;
   logic [2:0]  reg_write_dest, wb_op_dest;
   logic [15:0] reg_write_data;
   logic [7:0]  pending_mask;

   logic [2:0]  in3_valid, in3_ready, in3_we;
   logic [8:0]  in3_dest;
   logic [47:0] in3_data;
   logic        en3;
   logic [2:0]  dest3, op_dest3;
   logic [15:0] data3;
   logic [7:0]  mask3;

   int n_checks = 0;
   int n_fail   = 0;

   wb_arb_stage dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_we(in_we),
      .in_dest(in_dest), .in_data(in_data), .reg_write_en(reg_write_en),
      .reg_write_dest(reg_write_dest), .reg_write_data(reg_write_data),
      .wb_op_dest(wb_op_dest), .pending_mask(pending_mask)
   );

   wb_arb_stage #(.NUM_CH(3), .FIFO_DEPTH(2)) dut3 (
      .clk(clk), .rst(rst), .in_valid(in3_valid), .in_ready(in3_ready), .in_we(in3_we),
      .in_dest(in3_dest), .in_data(in3_data), .reg_write_en(en3),
      .reg_write_dest(dest3), .reg_write_data(data3),
      .wb_op_dest(op_dest3), .pending_mask(mask3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [1:0]  v;
      logic [1:0]  we;
      logic [2:0]  d0;
      logic [15:0] x0;
      logic [2:0]  d1;
      logic [15:0] x1;
      logic        en;
      logic [2:0]  dest;
      logic [15:0] data;
      logic [1:0]  rdy;
      logic [7:0]  mask;
   } vec_t;

   vec_t tv [21];

   function automatic vec_t mk(input logic [1:0] v, input logic [1:0] we,
                               input logic [2:0] d0, input logic [15:0] x0,
                               input logic [2:0] d1, input logic [15:0] x1,
                               input logic en, input logic [2:0] dest, input logic [15:0] data,
                               input logic [1:0] rdy, input logic [7:0] mask);
      vec_t r;
      r = {v, we, d0, x0, d1, x1, en, dest, data, rdy, mask};
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [1:0] v, input logic [1:0] we, input logic [2:0] d0,
                        input logic [15:0] x0, input logic [2:0] d1, input logic [15:0] x1);
      in_valid = v;
      in_we    = we;
      in_dest  = {d1, d0};
      in_data  = {x1, x0};
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_outputs(input string tag, input logic en, input logic [2:0] dest,
                              input logic [15:0] data, input logic [1:0] rdy, input logic [7:0] mask);
      chk({tag, ".en"},   32'(reg_write_en),   32'(en));
      chk({tag, ".dest"}, 32'(reg_write_dest), 32'(dest));
      chk({tag, ".data"}, 32'(reg_write_data), 32'(data));
      chk({tag, ".op"},   32'(wb_op_dest),     32'(en ? dest : 3'd0));
      chk({tag, ".rdy"},  32'(in_ready),       32'(rdy));
      chk({tag, ".mask"}, 32'(pending_mask),   32'(mask));
   endtask

   logic [2:0] exp3 [7];

   initial begin
      rst = 1'b0;
      drive(2'b00, 2'b00, 3'd0, 16'h0, 3'd0, 16'h0);
      in3_valid = 3'b000;
      in3_we    = 3'b000;
      in3_dest  = 9'd0;
      in3_data  = 48'd0;

      // rows: inputs before edge k, expected outputs after edge k
      tv[0]  = mk(2'b01, 2'b01, 3'd3, 16'h1234, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000, 2'b11, 8'h08);
      tv[1]  = mk(2'b00, 2'b00, 3'd0, 16'h0000, 3'd0, 16'h0000, 1'b1, 3'd3, 16'h1234, 2'b11, 8'h08);
      tv[2]  = mk(2'b00, 2'b00, 3'd0, 16'h0000, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000, 2'b11, 8'h00);
      tv[3]  = mk(2'b11, 2'b10, 3'd5, 16'h5555, 3'd0, 16'hBEEF, 1'b0, 3'd0, 16'h0000, 2'b11, 8'h00);
      tv[4]  = mk(2'b00, 2'b00, 3'd0, 16'h0000, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000, 2'b11, 8'h00);
      tv[5]  = mk(2'b11, 2'b11, 3'd1, 16'h0100, 3'd2, 16'h0200, 1'b0, 3'd0, 16'h0000, 2'b11, 8'h06);
      tv[6]  = mk(2'b11, 2'b11, 3'd1, 16'h0101, 3'd2, 16'h0201, 1'b1, 3'd2, 16'h0200, 2'b11, 8'h06);
      tv[7]  = mk(2'b11, 2'b11, 3'd1, 16'h0102, 3'd2, 16'h0202, 1'b1, 3'd1, 16'h0100, 2'b11, 8'h06);
      tv[8]  = mk(2'b11, 2'b11, 3'd1, 16'h0103, 3'd2, 16'h0203, 1'b1, 3'd2, 16'h0201, 2'b11, 8'h06);
      tv[9]  = mk(2'b11, 2'b11, 3'd1, 16'h0104, 3'd2, 16'h0204, 1'b1, 3'd1, 16'h0101, 2'b11, 8'h06);
      tv[10] = mk(2'b11, 2'b11, 3'd1, 16'h0105, 3'd2, 16'h0205, 1'b1, 3'd2, 16'h0202, 2'b10, 8'h06);
      tv[11] = mk(2'b11, 2'b11, 3'd1, 16'h0106, 3'd2, 16'h0206, 1'b1, 3'd1, 16'h0102, 2'b01, 8'h06);
      tv[12] = mk(2'b11, 2'b11, 3'd1, 16'h0106, 3'd2, 16'h0207, 1'b1, 3'd2, 16'h0203, 2'b10, 8'h06);
      tv[13] = mk(2'b00, 2'b00, 3'd0, 16'h0000, 3'd0, 16'h0000, 1'b1, 3'd1, 16'h0103, 2'b11, 8'h06);
      tv[14] = mk(2'b00, 2'b00, 3'd0, 16'h0000, 3'd0, 16'h0000, 1'b1, 3'd2, 16'h0204, 2'b11, 8'h06);
      tv[15] = mk(2'b00, 2'b00, 3'd0, 16'h0000, 3'd0, 16'h0000, 1'b1, 3'd1, 16'h0104, 2'b11, 8'h06);
      tv[16] = mk(2'b00, 2'b00, 3'd0, 16'h0000, 3'd0, 16'h0000, 1'b1, 3'd2, 16'h0205, 2'b11, 8'h06);
      tv[17] = mk(2'b00, 2'b00, 3'd0, 16'h0000, 3'd0, 16'h0000, 1'b1, 3'd1, 16'h0105, 2'b11, 8'h06);
      tv[18] = mk(2'b00, 2'b00, 3'd0, 16'h0000, 3'd0, 16'h0000, 1'b1, 3'd2, 16'h0206, 2'b11, 8'h06);
      tv[19] = mk(2'b00, 2'b00, 3'd0, 16'h0000, 3'd0, 16'h0000, 1'b1, 3'd1, 16'h0106, 2'b11, 8'h02);
      tv[20] = mk(2'b00, 2'b00, 3'd0, 16'h0000, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000, 2'b11, 8'h00);

      exp3[0] = 3'd0; exp3[1] = 3'd1; exp3[2] = 3'd2; exp3[3] = 3'd3;
      exp3[4] = 3'd1; exp3[5] = 3'd2; exp3[6] = 3'd3;

      #1;
      chk_outputs("reset", 1'b0, 3'd0, 16'h0000, 2'b00, 8'h00);
      chk("reset.rdy3", 32'(in3_ready), 32'd0);

      step();
      step();
      rst = 1'b1;
      #1;
      chk("release.rdy", 32'(in_ready), 32'h3);
      chk("release.rdy3", 32'(in3_ready), 32'h7);

      for (int k = 0; k < 21; k++) begin
         drive(tv[k].v, tv[k].we, tv[k].d0, tv[k].x0, tv[k].d1, tv[k].x1);
         step();
         chk_outputs($sformatf("vec%0d", k + 1), tv[k].en, tv[k].dest, tv[k].data,
                     tv[k].rdy, tv[k].mask);
      end

      // queue three entries plus one on the output, then reset between edges
      drive(2'b11, 2'b11, 3'd4, 16'h4444, 3'd6, 16'h6666);
      step();
      chk_outputs("q22", 1'b0, 3'd0, 16'h0000, 2'b11, 8'h50);
      step();
      chk_outputs("q23", 1'b1, 3'd6, 16'h6666, 2'b11, 8'h50);
      drive(2'b00, 2'b00, 3'd0, 16'h0, 3'd0, 16'h0);
      #3;
      rst = 1'b0;
      #1;
      chk_outputs("midrst", 1'b0, 3'd0, 16'h0000, 2'b00, 8'h00);
      step();
      step();
      rst = 1'b1;
      #1;
      chk("rerel.rdy", 32'(in_ready), 32'h3);
      for (int k = 0; k < 3; k++) begin
         step();
         chk($sformatf("post_rst%0d.en", k), 32'(reg_write_en), 32'd0);
         chk($sformatf("post_rst%0d.mask", k), 32'(pending_mask), 32'd0);
      end

      // three-channel build, all saturated: grants 0,1,2,0,1,2 seen as dests 1,2,3
      in3_valid = 3'b111;
      in3_we    = 3'b111;
      in3_dest  = {3'd3, 3'd2, 3'd1};
      in3_data  = {16'h0302, 16'h0301, 16'h0300};
      for (int k = 0; k < 7; k++) begin
         step();
         chk($sformatf("rr3_%0d.en", k), 32'(en3), 32'(exp3[k] != 3'd0));
         chk($sformatf("rr3_%0d.dest", k), 32'(dest3), 32'(exp3[k]));
      end
      in3_valid = 3'b000;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
